// File: rtl/sa_os_tile.sv
// Output-stationary systolic tile computing C = A x B.
// PE(r,c) keeps C[r][c]; a operands travel east, b operands travel south.
// Operand beats are skewed on entry so beat k meets at PE(r,c) r+c+1 cycles
// after acceptance. Each skewed operand carries a valid bit, so bubbles
// never accumulate. Finished rows are drained one per handshake.
module sa_os_tile #(
    parameter int SA_ROWS   = 4,
    parameter int SA_COLS   = 4,
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 32,
    parameter int K_MAX     = 256,
    localparam int KW       = $clog2(K_MAX + 1),
    localparam int RW       = (SA_ROWS > 1) ? $clog2(SA_ROWS) : 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_start,
    input  logic [KW-1:0]                        i_k_len,
    input  logic                                 i_valid,
    output logic                                 o_ready,
    input  logic [SA_ROWS-1:0][IN_WIDTH-1:0]     i_a,
    input  logic [SA_COLS-1:0][IN_WIDTH-1:0]     i_b,
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic [SA_COLS-1:0][ACC_WIDTH-1:0]    o_c,
    output logic [RW-1:0]                        o_row_idx,
    output logic                                 o_last,
    output logic                                 o_busy,
    output logic                                 o_done
);

    // Cycles for the last accepted beat to reach PE(SA_ROWS-1, SA_COLS-1).
    localparam int FLUSH_LEN = SA_ROWS + SA_COLS - 1;
    localparam int FW        = $clog2(FLUSH_LEN + 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DRAIN} state_t;

    state_t          state_reg;
    logic [KW-1:0]   k_len_reg;
    logic [KW-1:0]   beat_cnt_reg;
    logic [KW-1:0]   beat_cnt_next;
    logic [FW-1:0]   flush_cnt_reg;
    logic [RW-1:0]   row_idx_reg;
    logic            ready_reg;
    logic            valid_reg;
    logic            done_reg;
    logic            accept;
    logic            clear;

    // Skewed operands entering the array edges, and inter-PE links.
    logic signed [IN_WIDTH-1:0]  a_west    [SA_ROWS];
    logic                        a_west_v  [SA_ROWS];
    logic signed [IN_WIDTH-1:0]  b_north   [SA_COLS];
    logic                        b_north_v [SA_COLS];
    logic signed [IN_WIDTH-1:0]  a_pass    [SA_ROWS][SA_COLS];
    logic                        a_pass_v  [SA_ROWS][SA_COLS];
    logic signed [IN_WIDTH-1:0]  b_pass    [SA_ROWS][SA_COLS];
    logic                        b_pass_v  [SA_ROWS][SA_COLS];
    logic signed [ACC_WIDTH-1:0] acc_out   [SA_ROWS][SA_COLS];

    // ready_reg is only ever high in COMPUTE, so this also masks i_valid elsewhere.
    assign accept        = i_valid && ready_reg;
    assign clear         = (state_reg == IDLE) && i_start;
    assign beat_cnt_next = beat_cnt_reg + KW'(1);

    assign o_ready   = ready_reg;
    assign o_valid   = valid_reg;
    assign o_done    = done_reg;
    assign o_row_idx = row_idx_reg;
    assign o_last    = valid_reg && (row_idx_reg == RW'(SA_ROWS - 1));
    assign o_busy    = (state_reg != IDLE);

    // Job sequencing with registered handshake outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            k_len_reg     <= '0;
            beat_cnt_reg  <= '0;
            flush_cnt_reg <= '0;
            row_idx_reg   <= '0;
            ready_reg     <= 1'b0;
            valid_reg     <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        k_len_reg     <= i_k_len;
                        beat_cnt_reg  <= '0;
                        flush_cnt_reg <= '0;
                        row_idx_reg   <= '0;
                        if (i_k_len == '0) begin
                            // Nothing to reduce: cleared accumulators drain as zero rows.
                            state_reg <= DRAIN;
                            valid_reg <= 1'b1;
                        end else begin
                            state_reg <= COMPUTE;
                            ready_reg <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (accept) begin
                        beat_cnt_reg <= beat_cnt_next;
                        if (beat_cnt_next == k_len_reg) begin
                            state_reg <= FLUSH;
                            ready_reg <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt_reg == FW'(FLUSH_LEN - 1)) begin
                        state_reg <= DRAIN;
                        valid_reg <= 1'b1;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg + FW'(1);
                    end
                end
                DRAIN: begin
                    if (done_reg) begin
                        // One extra DRAIN cycle carries the done pulse, so a start
                        // coinciding with it is not taken.
                        done_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (valid_reg && i_ready) begin
                        if (row_idx_reg == RW'(SA_ROWS - 1)) begin
                            valid_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            row_idx_reg <= row_idx_reg + RW'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    genvar gi, gj;

    // Row skew: row gi of a passes through gi+1 registers before column 0.
    for (gi = 0; gi < SA_ROWS; gi++) begin : g_a_skew
        logic [IN_WIDTH-1:0] sk_data_reg [gi+1];
        logic                sk_v_reg    [gi+1];
        // Shift the row delay line every cycle; the valid bit marks real beats.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                for (int s = 0; s <= gi; s++) begin
                    sk_data_reg[s] <= '0;
                    sk_v_reg[s]    <= 1'b0;
                end
            end else begin
                sk_data_reg[0] <= i_a[gi];
                sk_v_reg[0]    <= accept;
                for (int s = 1; s <= gi; s++) begin
                    sk_data_reg[s] <= sk_data_reg[s-1];
                    sk_v_reg[s]    <= sk_v_reg[s-1];
                end
            end
        end
        assign a_west[gi]   = sk_data_reg[gi];
        assign a_west_v[gi] = sk_v_reg[gi];
    end

    // Column skew: column gi of b passes through gi+1 registers before row 0.
    for (gi = 0; gi < SA_COLS; gi++) begin : g_b_skew
        logic [IN_WIDTH-1:0] sk_data_reg [gi+1];
        logic                sk_v_reg    [gi+1];
        // Shift the column delay line every cycle; the valid bit marks real beats.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                for (int s = 0; s <= gi; s++) begin
                    sk_data_reg[s] <= '0;
                    sk_v_reg[s]    <= 1'b0;
                end
            end else begin
                sk_data_reg[0] <= i_b[gi];
                sk_v_reg[0]    <= accept;
                for (int s = 1; s <= gi; s++) begin
                    sk_data_reg[s] <= sk_data_reg[s-1];
                    sk_v_reg[s]    <= sk_v_reg[s-1];
                end
            end
        end
        assign b_north[gi]   = sk_data_reg[gi];
        assign b_north_v[gi] = sk_v_reg[gi];
    end

    // Processing elements.
    for (gi = 0; gi < SA_ROWS; gi++) begin : g_row
        for (gj = 0; gj < SA_COLS; gj++) begin : g_col
            logic signed [IN_WIDTH-1:0]   a_in;
            logic signed [IN_WIDTH-1:0]   b_in;
            logic                         a_in_v;
            logic                         b_in_v;
            logic signed [IN_WIDTH-1:0]   a_reg;
            logic signed [IN_WIDTH-1:0]   b_reg;
            logic                         a_v_reg;
            logic                         b_v_reg;
            logic signed [ACC_WIDTH-1:0]  acc_reg;
            logic signed [2*IN_WIDTH-1:0] prod;

            if (gj == 0) begin : g_a_edge
                assign a_in   = a_west[gi];
                assign a_in_v = a_west_v[gi];
            end else begin : g_a_link
                assign a_in   = a_pass[gi][gj-1];
                assign a_in_v = a_pass_v[gi][gj-1];
            end

            if (gi == 0) begin : g_b_edge
                assign b_in   = b_north[gj];
                assign b_in_v = b_north_v[gj];
            end else begin : g_b_link
                assign b_in   = b_pass[gi-1][gj];
                assign b_in_v = b_pass_v[gi-1][gj];
            end

            assign prod = a_in * b_in;

            // Forward operands one hop and accumulate when both sides carry a beat.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    a_reg   <= '0;
                    b_reg   <= '0;
                    a_v_reg <= 1'b0;
                    b_v_reg <= 1'b0;
                    acc_reg <= '0;
                end else begin
                    a_reg   <= a_in;
                    b_reg   <= b_in;
                    a_v_reg <= a_in_v;
                    b_v_reg <= b_in_v;
                    if (clear) begin
                        acc_reg <= '0;
                    end else if (a_in_v && b_in_v) begin
                        acc_reg <= acc_reg + ACC_WIDTH'(prod);
                    end
                end
            end

            assign a_pass[gi][gj]   = a_reg;
            assign a_pass_v[gi][gj] = a_v_reg;
            assign b_pass[gi][gj]   = b_reg;
            assign b_pass_v[gi][gj] = b_v_reg;
            assign acc_out[gi][gj]  = acc_reg;
        end
    end

    // Present the selected result row while draining; zero otherwise.
    always_comb begin
        for (int c = 0; c < SA_COLS; c++) begin
            o_c[c] = valid_reg ? acc_out[row_idx_reg][c] : '0;
        end
    end

endmodule

// File: tb/tb_sa_os_tile.sv
// Directed self-checking bench for sa_os_tile (4x4, plus a 16-bit accumulator copy).
module tb_sa_os_tile;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int IW = 8;
    localparam int AW = 32;
    localparam int KM = 256;
    localparam int KW = $clog2(KM + 1);

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [KW-1:0]           k_len;
    logic                    valid;
    logic                    ready_o;
    logic [R-1:0][IW-1:0]    a;
    logic [C-1:0][IW-1:0]    b;
    logic                    out_valid;
    logic                    out_ready;
    logic [C-1:0][AW-1:0]    c_out;
    logic [1:0]              row_idx;
    logic                    last;
    logic                    busy;
    logic                    done;

    logic                    ready16;
    logic                    valid16;
    logic [C-1:0][15:0]      c16;
    logic [1:0]              row16;
    logic                    last16;
    logic                    busy16;
    logic                    done16;

    sa_os_tile dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_k_len   (k_len),
        .i_valid   (valid),
        .o_ready   (ready_o),
        .i_a       (a),
        .i_b       (b),
        .o_valid   (out_valid),
        .i_ready   (out_ready),
        .o_c       (c_out),
        .o_row_idx (row_idx),
        .o_last    (last),
        .o_busy    (busy),
        .o_done    (done)
    );

    sa_os_tile #(.ACC_WIDTH(16)) dut16 (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_k_len   (k_len),
        .i_valid   (valid),
        .o_ready   (ready16),
        .i_a       (a),
        .i_b       (b),
        .o_valid   (valid16),
        .i_ready   (out_ready),
        .o_c       (c16),
        .o_row_idx (row16),
        .o_last    (last16),
        .o_busy    (busy16),
        .o_done    (done16)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int first_acc;
    int first_valid;

    logic signed [7:0] ta  [16][4];
    logic signed [7:0] tbm [16][4];
    bit                vpat [8];
    logic [127:0]      exp_rows [4];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Plain matrix product over the first k stored beats.
    task automatic model(input int k);
        int s;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                s = 0;
                for (int kk = 0; kk < k; kk++) s = s + int'(ta[kk][r]) * int'(tbm[kk][c]);
                exp_rows[r][c*32 +: 32] = s;
            end
        end
    endtask

    task automatic run_job(input int k, input int npat);
        int idx = 0;
        int p = 0;
        int guard = 0;
        first_acc   = -1;
        first_valid = -1;
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(k);
        @(negedge clk);
        start = 1'b0;
        while (idx < k && guard < 100) begin
            valid = (npat == 0) ? 1'b1 : vpat[p % npat];
            p++;
            for (int r = 0; r < R; r++) a[r] = ta[idx][r];
            for (int c = 0; c < C; c++) b[c] = tbm[idx][c];
            if (valid && ready_o) begin
                if (idx == 0) first_acc = cycle;
                idx++;
            end
            @(negedge clk);
            guard++;
        end
        valid = 1'b0;
        $display("job k=%0d: %0d beats accepted", k, idx);
        check("beats_done", 128'(idx), 128'(k));
        check("ready_drop", 128'(ready_o), 128'(0));
    endtask

    task automatic drain(input int stall_row, input int stall_n, input bit chk16,
                         input logic [63:0] exp16, input bit hold_start);
        int row = 0;
        int guard = 0;
        int stalls = 0;
        bit stall;
        while (row < R && guard < 200) begin
            if (out_valid) begin
                if (first_valid < 0) first_valid = cycle;
                stall = (row == stall_row) && (stalls < stall_n);
                out_ready = !stall;
                check($sformatf("row%0d_idx", row), 128'(row_idx), 128'(row));
                check($sformatf("row%0d_c", row), 128'(c_out), exp_rows[row]);
                check($sformatf("row%0d_last", row), 128'(last), 128'(row == R - 1));
                if (chk16) check($sformatf("row%0d_c16", row), 128'(c16), 128'(exp16));
                if (stall) stalls++;
                else begin
                    $display("row %0d accepted c=%h", row, c_out);
                    row++;
                end
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b1;
        check("drain_rows", 128'(row), 128'(R));
        check("done_pulse", 128'(done), 128'(1));
        check("valid_off", 128'(out_valid), 128'(0));
        @(negedge clk);
        check("done_single", 128'(done), 128'(0));
        check("back_idle", 128'(busy), 128'(0));
        if (hold_start) start = 1'b0;
    endtask

    initial begin
        int nbad;
        rst = 1'b1; start = 1'b0; k_len = '0; valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_ctl", 128'({ready_o, out_valid, row_idx, last, busy, done}), 128'(0));
        check("rst_c", 128'(c_out), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // Identity A, B[k][c] = 4k+c: rows of C equal rows of B.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) begin
                ta[k][i]  = (i == k) ? 8'sd1 : 8'sd0;
                tbm[k][i] = 8'(k * 4 + i);
            end
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) exp_rows[r][c*32 +: 32] = 32'(r * 4 + c);
        run_job(4, 0);
        drain(-1, 0, 1'b0, 64'd0, 1'b0);
        check("first_valid_latency", 128'(first_valid - first_acc + 1), 128'(12));

        // -128 * -128 twice = 32768 everywhere.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                ta[k][i] = -8'sd128;
                tbm[k][i] = -8'sd128;
            end
        for (int r = 0; r < R; r++) exp_rows[r] = {4{32'h0000_8000}};
        run_job(2, 0);
        drain(-1, 0, 1'b0, 64'd0, 1'b0);

        // -3 * 5 once = -15.
        for (int i = 0; i < 4; i++) begin
            ta[0][i] = -8'sd3;
            tbm[0][i] = 8'sd5;
        end
        for (int r = 0; r < R; r++) exp_rows[r] = {4{32'hFFFF_FFF1}};
        run_job(1, 0);
        drain(-1, 0, 1'b0, 64'd0, 1'b0);

        // k=3 with bubbles 1,0,0,1,0,1; junk beats offered after the job must be ignored.
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) begin
                ta[k][i]  = 8'(k * 7 + i * 3 - 10);
                tbm[k][i] = 8'(5 - k * 4 + i * 2);
            end
        vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1; vpat[4] = 0; vpat[5] = 1;
        model(3);
        run_job(3, 6);
        valid = 1'b1;
        a = {4{8'sd127}};
        b = {4{8'sd127}};
        drain(-1, 0, 1'b0, 64'd0, 1'b0);
        valid = 1'b0;

        // Backpressure: row 1 stalled 5 cycles.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) begin
                ta[k][i]  = 8'(i - k * 2 + 1);
                tbm[k][i] = 8'(i * 3 - k - 2);
            end
        model(4);
        run_job(4, 0);
        drain(1, 5, 1'b0, 64'd0, 1'b0);

        // k=0: zero rows without flush; start held through DRAIN and the done cycle.
        for (int r = 0; r < R; r++) exp_rows[r] = '0;
        run_job(0, 0);
        check("no_flush", 128'(out_valid), 128'(1));
        start = 1'b1;
        k_len = KW'(3);
        drain(-1, 0, 1'b0, 64'd0, 1'b1);

        // 3 x 127*127 = 48387: wraps to -17149 in 16 bits.
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) begin
                ta[k][i]  = 8'sd127;
                tbm[k][i] = 8'sd127;
            end
        for (int r = 0; r < R; r++) exp_rows[r] = {4{32'h0000_BD03}};
        run_job(3, 0);
        drain(-1, 0, 1'b1, {4{16'hBD03}}, 1'b0);

        // Reset in the middle of FLUSH abandons the job.
        run_job(3, 0);
        @(negedge clk);
        check("flush_busy", 128'(busy), 128'(1));
        #2 rst = 1'b1;
        #1;
        check("midrst_ctl", 128'({ready_o, out_valid, row_idx, last, busy, done}), 128'(0));
        check("midrst_c", 128'(c_out), 128'(0));
        check("midrst_c16", 128'(c16), 128'(0));
        check("midrst16_ctl", 128'({ready16, valid16, row16, last16, busy16, done16}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        nbad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid || busy) nbad++;
        end
        check("no_partial_row", 128'(nbad), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
